// File: rtl/apb_clint_slv.sv
// ============================================================================
// Module   : apb_clint_slv
// Purpose  : APB3 completer for the core-complex CLINT window. It holds a 64b
//            MTIME counter advanced by a prescaled RTC tick, a 64b MTIMECMP
//            compare register and MSIP. It drives the machine timer and
//            software interrupts.
// Ports    : clk_i/rst_i      clock, synchronous active-high reset
//            paddr_i..pprot_i APB request (only paddr_i[11:0] is decoded,
//                             pprot_i is ignored)
//            pready_o, prdata_o, pslverr_o
//                             APB response, non-zero only in the completion
//                             cycle
//            tick_i           RTC tick enable, one clk wide
//            mtip_o, msip_o   timer / software interrupt
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_clint_slv #(
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] PRESC_RST   = 16'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  input  logic [2:0]  pprot_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o,
  input  logic        tick_i,
  output logic        mtip_o,
  output logic        msip_o
);

  localparam logic [3:0]  c_WS         = 4'(WAIT_STATES);
  localparam logic [11:0] c_OFF_MSIP   = 12'h000;
  localparam logic [11:0] c_OFF_CMP_LO = 12'h008;
  localparam logic [11:0] c_OFF_CMP_HI = 12'h00C;
  localparam logic [11:0] c_OFF_MT_LO  = 12'h010;
  localparam logic [11:0] c_OFF_MT_HI  = 12'h014;
  localparam logic [11:0] c_OFF_CTRL   = 12'h018;
  localparam logic [11:0] c_OFF_PRESC  = 12'h01C;

  // The setup phase is recognised combinationally from psel&!penable while
  // idle; the registered state only has to remember that an access is open.
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_done;

  logic        r_msip;
  logic        r_en;
  logic [15:0] r_presc;
  logic [15:0] r_pcnt;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_shadow;
  logic        r_mtip;

  logic [11:0] w_off;
  logic        w_map;
  logic        w_err;
  logic [31:0] w_rdata;
  logic        w_wr;
  logic        w_rd;
  logic        w_inc;
  logic [31:0] w_wval;
  logic        w_unused;

  assign w_unused = ^{pprot_i, paddr_i[31:12]};
  assign w_off    = paddr_i[11:0];

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Transfer FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 4'd0;
        if (psel_i && !penable_i) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (!psel_i) begin
          // Requester withdrew before completion: abandon without commit.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (penable_i) begin
          if (r_cnt == c_WS) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Address decode and read mux (MTIME_HI reads the shadow, not live)
  always_comb begin
    w_map   = 1'b1;
    w_rdata = 32'd0;
    case (w_off)
      c_OFF_MSIP:   w_rdata = {31'd0, r_msip};
      c_OFF_CMP_LO: w_rdata = r_mtimecmp[31:0];
      c_OFF_CMP_HI: w_rdata = r_mtimecmp[63:32];
      c_OFF_MT_LO:  w_rdata = r_mtime[31:0];
      c_OFF_MT_HI:  w_rdata = r_shadow;
      c_OFF_CTRL:   w_rdata = {31'd0, r_en};
      c_OFF_PRESC:  w_rdata = {16'd0, r_presc};
      default:      w_map   = 1'b0;
    endcase
  end

  assign w_err     = !w_map || (paddr_i[1:0] != 2'b00);
  assign w_wr      = w_done && pwrite_i && !w_err;
  assign w_rd      = w_done && !pwrite_i && !w_err;
  assign pready_o  = w_done;
  assign pslverr_o = w_done && w_err;
  assign prdata_o  = (w_done && !w_err) ? w_rdata : 32'd0;

  // Byte-merged write value for whichever register is addressed
  always_comb begin
    w_wval = 32'd0;
    case (w_off)
      c_OFF_CMP_LO: w_wval = f_merge(r_mtimecmp[31:0],  pwdata_i, pstrb_i);
      c_OFF_CMP_HI: w_wval = f_merge(r_mtimecmp[63:32], pwdata_i, pstrb_i);
      c_OFF_MT_LO:  w_wval = f_merge(r_mtime[31:0],     pwdata_i, pstrb_i);
      c_OFF_MT_HI:  w_wval = f_merge(r_mtime[63:32],    pwdata_i, pstrb_i);
      c_OFF_PRESC:  w_wval = f_merge({16'd0, r_presc},  pwdata_i, pstrb_i);
      default:      w_wval = f_merge(32'd0,             pwdata_i, pstrb_i);
    endcase
  end

  // Prescaler wraps after PRESC+1 ticks and produces one MTIME increment.
  assign w_inc = r_en && tick_i && (r_pcnt == r_presc);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_msip     <= 1'b0;
      r_en       <= 1'b0;
      r_presc    <= PRESC_RST;
      r_pcnt     <= 16'd0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_shadow   <= 32'd0;
      r_mtip     <= 1'b0;
    end else begin
      r_mtip <= (r_mtime >= r_mtimecmp);

      if (w_wr && (w_off == c_OFF_PRESC)) begin
        r_pcnt <= 16'd0;
      end else if (r_en && tick_i) begin
        r_pcnt <= w_inc ? 16'd0 : r_pcnt + 16'd1;
      end

      if (w_rd && (w_off == c_OFF_MT_LO)) r_shadow <= r_mtime[63:32];

      // An APB write to either MTIME half suppresses that cycle's increment
      // entirely, so the untouched half keeps its pre-increment value.
      if (w_wr && (w_off == c_OFF_MT_LO)) begin
        r_mtime[31:0] <= w_wval;
      end else if (w_wr && (w_off == c_OFF_MT_HI)) begin
        r_mtime[63:32] <= w_wval;
        r_shadow       <= w_wval;
      end else if (w_inc) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (w_wr) begin
        case (w_off)
          c_OFF_MSIP:   if (pstrb_i[0]) r_msip <= pwdata_i[0];
          c_OFF_CMP_LO: r_mtimecmp[31:0]  <= w_wval;
          c_OFF_CMP_HI: r_mtimecmp[63:32] <= w_wval;
          c_OFF_CTRL:   if (pstrb_i[0]) r_en <= pwdata_i[0];
          c_OFF_PRESC:  r_presc <= w_wval[15:0];
          default: ;
        endcase
      end
    end
  end

  assign mtip_o = r_mtip;
  assign msip_o = r_msip;

endmodule

`default_nettype wire

// File: tb/tb_apb_clint_slv.sv
// ============================================================================
// Module   : tb_apb_clint_slv
// Purpose  : Self-checking bench for apb_clint_slv (WAIT_STATES=2) with a
//            register-level reference model of the CLINT window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_clint_slv;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        tick = 1'b0;
  logic        mtip;
  logic        msip;

  always #5 clk = ~clk;

  apb_clint_slv #(.WAIT_STATES(WS), .PRESC_RST(16'd0)) dut (
    .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .psel_i(psel),
    .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pstrb_i(pstrb), .pprot_i(pprot), .pready_o(pready),
    .prdata_o(prdata), .pslverr_o(pslverr), .tick_i(tick),
    .mtip_o(mtip), .msip_o(msip)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_en;
  logic [15:0] m_presc;
  int          m_pcnt;
  logic [31:0] m_shadow;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0; m_en = 1'b0;
    m_presc = 16'd0; m_pcnt = 0; m_shadow = 32'd0;
  endtask

  function automatic bit m_bad(input logic [31:0] a);
    logic [11:0] o;
    o = a[11:0];
    return (a[1:0] != 2'b00) ||
           !(o inside {12'h000, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'h01C});
  endfunction

  function automatic logic [31:0] m_lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] st);
    logic [7:0] by [4];
    for (int b = 0; b < 4; b++) by[b] = st[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return {by[3], by[2], by[1], by[0]};
  endfunction

  task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    e = m_bad(a);
    d = 32'd0;
    if (!e) begin
      case (a[11:0])
        12'h000: d = {31'd0, m_msip};
        12'h008: d = m_cmp[31:0];
        12'h00C: d = m_cmp[63:32];
        12'h010: d = m_mtime[31:0];
        12'h014: d = m_shadow;
        12'h018: d = {31'd0, m_en};
        default: d = {16'd0, m_presc};
      endcase
    end
  endtask

  // One clock edge of the model: optional completed transfer plus tick.
  task automatic m_edge(input bit xfer, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input bit tk);
    bit          inc;
    logic [31:0] v;
    inc = 1'b0;
    if (tk && m_en) begin
      if (m_pcnt == int'(m_presc)) begin m_pcnt = 0; inc = 1'b1; end
      else m_pcnt++;
    end
    if (xfer && !m_bad(a)) begin
      if (!wr) begin
        if (a[11:0] == 12'h010) m_shadow = m_mtime[63:32];
      end else begin
        case (a[11:0])
          12'h000: if (st[0]) m_msip = wd[0];
          12'h008: m_cmp[31:0]  = m_lanes(m_cmp[31:0], wd, st);
          12'h00C: m_cmp[63:32] = m_lanes(m_cmp[63:32], wd, st);
          12'h010: begin m_mtime[31:0] = m_lanes(m_mtime[31:0], wd, st); inc = 1'b0; end
          12'h014: begin
            v = m_lanes(m_mtime[63:32], wd, st);
            m_mtime[63:32] = v; m_shadow = v; inc = 1'b0;
          end
          12'h018: if (st[0]) m_en = wd[0];
          default: begin
            v = m_lanes({16'd0, m_presc}, wd, st);
            m_presc = v[15:0]; m_pcnt = 0;
          end
        endcase
      end
    end
    if (inc) m_mtime = m_mtime + 64'd1;
  endtask

  // All stimulus tasks start and end 1ns after a rising edge.
  task automatic apb(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input bit tk,
                     output logic [31:0] rd, output logic err);
    int n;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    pprot = 3'($urandom);
    @(posedge clk) #1;
    penable = 1'b1;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (pready === 1'b1) break;
      @(posedge clk) #1;
    end
    chk("access_cycles", 64'(n), 64'(WS + 1));
    rd = prdata; err = pslverr;
    if (tk) tick = 1'b1;
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0; tick = 1'b0;
    m_edge(1'b1, wr, a, wd, st, tk);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a);
    logic [31:0] ed, d;
    logic        ee, e;
    m_read(a, ed, ee);
    apb(1'b0, a, 32'd0, 4'h0, 1'b0, d, e);
    chk({tag, "_data"}, 64'(d), 64'(ed));
    chk({tag, "_err"}, 64'(e), 64'(ee));
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input bit tk);
    logic [31:0] d;
    logic        e;
    apb(1'b1, a, wd, st, tk, d, e);
    chk({tag, "_err"}, 64'(e), 64'(m_bad(a)));
  endtask

  task automatic irq_chk(input string tag);
    @(posedge clk) #1;
    m_edge(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    chk({tag, "_mtip"}, 64'(mtip), 64'(m_mtime >= m_cmp));
    chk({tag, "_msip"}, 64'(msip), 64'(m_msip));
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(posedge clk) #1;
      tick = 1'b0;
      m_edge(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b1);
    end
  endtask

  localparam logic [31:0] BASE = 32'h0600_5000;

  initial begin
    logic [31:0] d, lo, hi;
    logic        e;
    logic [63:0] start;
    logic [11:0] offs [10];
    offs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
             12'h014, 12'h018, 12'h01C, 12'h020, 12'h002};

    // Reset
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pready", 64'(pready), 64'd0);
    chk("rst_prdata", 64'(prdata), 64'd0);
    chk("rst_pslverr", 64'(pslverr), 64'd0);
    chk("rst_mtip", 64'(mtip), 64'd0);
    chk("rst_msip", 64'(msip), 64'd0);

    // MTIMECMP_HI after reset, with wait states
    apb(1'b0, BASE + 32'h00C, 32'd0, 4'h0, 1'b0, d, e);
    chk("cmp_hi_rst", 64'(d), 64'hFFFF_FFFF);
    chk("cmp_hi_err", 64'(e), 64'd0);
    foreach (offs[i]) rd_chk("rst_map", BASE + 32'(offs[i]));

    // Carry from low to high half on a single tick
    wr_chk("mt_lo", BASE + 32'h010, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr_chk("mt_hi", BASE + 32'h014, 32'h0, 4'hF, 1'b0);
    wr_chk("en", BASE + 32'h018, 32'h1, 4'hF, 1'b0);
    wr_chk("presc0", BASE + 32'h01C, 32'h0, 4'hF, 1'b0);
    tick_n(1);
    apb(1'b0, BASE + 32'h010, 32'd0, 4'h0, 1'b0, lo, e);
    apb(1'b0, BASE + 32'h014, 32'd0, 4'h0, 1'b0, hi, e);
    chk("carry_mtime", {hi, lo}, 64'h1_0000_0000);

    // Prescaler of 3: 8 ticks -> +2; disabled -> hold
    wr_chk("presc3", BASE + 32'h01C, 32'h3, 4'hF, 1'b0);
    start = m_mtime;
    tick_n(8);
    apb(1'b0, BASE + 32'h010, 32'd0, 4'h0, 1'b0, lo, e);
    apb(1'b0, BASE + 32'h014, 32'd0, 4'h0, 1'b0, hi, e);
    chk("presc_adv", {hi, lo} - start, 64'd2);
    wr_chk("dis", BASE + 32'h018, 32'h0, 4'hF, 1'b0);
    tick_n(4);
    apb(1'b0, BASE + 32'h010, 32'd0, 4'h0, 1'b0, lo, e);
    apb(1'b0, BASE + 32'h014, 32'd0, 4'h0, 1'b0, hi, e);
    chk("dis_hold", {hi, lo} - start, 64'd2);

    // Timer interrupt edge timing
    wr_chk("presc0b", BASE + 32'h01C, 32'h0, 4'hF, 1'b0);
    wr_chk("mt_lo4", BASE + 32'h010, 32'h4, 4'hF, 1'b0);
    wr_chk("mt_hi0", BASE + 32'h014, 32'h0, 4'hF, 1'b0);
    wr_chk("cmp_lo5", BASE + 32'h008, 32'h5, 4'hF, 1'b0);
    wr_chk("cmp_hi0", BASE + 32'h00C, 32'h0, 4'hF, 1'b0);
    wr_chk("en1", BASE + 32'h018, 32'h1, 4'hF, 1'b0);
    irq_chk("below_cmp");
    tick_n(1);
    chk("mtip_lag", 64'(mtip), 64'd0);
    @(posedge clk) #1;
    m_edge(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    chk("mtip_rise", 64'(mtip), 64'd1);
    wr_chk("cmp_hi_max", BASE + 32'h00C, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr_chk("cmp_lo_max", BASE + 32'h008, 32'hFFFF_FFFF, 4'hF, 1'b0);
    irq_chk("cmp_raise");
    chk("mtip_fall", 64'(mtip), 64'd0);

    // Error responses and empty strobe
    wr_chk("wr_004", BASE + 32'h004, 32'h1234_5678, 4'hF, 1'b0);
    wr_chk("wr_mis", BASE + 32'h002, 32'h1, 4'hF, 1'b0);
    wr_chk("wr_020", BASE + 32'h020, 32'h1, 4'hF, 1'b0);
    wr_chk("msip_nostrb", BASE + 32'h000, 32'h1, 4'h0, 1'b0);
    irq_chk("nostrb");
    chk("msip_nostrb_pin", 64'(msip), 64'd0);
    foreach (offs[i]) rd_chk("post_err", BASE + 32'(offs[i]));

    // Write to MTIME_LO coinciding with an increment: no carry
    wr_chk("mt_lo_ff", BASE + 32'h010, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr_chk("mt_hi_0", BASE + 32'h014, 32'h0, 4'hF, 1'b0);
    wr_chk("mt_lo_tick", BASE + 32'h010, 32'h10, 4'hF, 1'b1);
    apb(1'b0, BASE + 32'h010, 32'd0, 4'h0, 1'b0, lo, e);
    apb(1'b0, BASE + 32'h014, 32'd0, 4'h0, 1'b0, hi, e);
    chk("wr_vs_inc", {hi, lo}, 64'h10);

    // Reset in the middle of an MSIP write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE; pwdata = 32'h1; pstrb = 4'hF;
    @(posedge clk) #1;
    penable = 1'b1;
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    chk("midrst_pready", 64'(pready), 64'd0);
    chk("midrst_msip", 64'(msip), 64'd0);
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0;
    m_edge(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    irq_chk("midrst");
    rd_chk("midrst_msip_rd", BASE);
    rd_chk("midrst_cmp_rd", BASE + 32'h00C);

    // Randomised traffic against the model
    for (int it = 0; it < 80; it++) begin
      logic [31:0] a, wd;
      a = BASE + 32'(offs[$urandom_range(0, 9)]);
      wd = $urandom;
      if (a[11:0] == 12'h01C) wd = {wd[31:16], 16'($urandom_range(0, 3))};
      case ($urandom_range(0, 3))
        0: begin
          wr_chk("rnd_wr", a, wd, 4'($urandom), 1'($urandom));
          irq_chk("rnd_wr");
        end
        1: rd_chk("rnd_rd", a);
        2: tick_n($urandom_range(1, 6));
        default: irq_chk("rnd_irq");
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
